// File: rtl/pc_ras_unit_if.sv
// Fetch-PC unit bus: redirect controls in, PC and return-stack status out.
// PC_TRAP_EN adds the trap request/vector inputs and the epc output.
interface pc_ras_unit_if #(
  parameter int XLEN = 32
);
  logic            hold;
  logic [2:0]      mode;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] PC;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_err;
`ifdef PC_TRAP_EN
  logic            trap_req;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] epc;

  modport master (
    output hold, mode, target, trap_req, trap_vec,
    input  PC, misalign, ras_empty, ras_full, ras_err, epc
  );
  modport slave (
    input  hold, mode, target, trap_req, trap_vec,
    output PC, misalign, ras_empty, ras_full, ras_err, epc
  );
`else
  modport master (
    output hold, mode, target,
    input  PC, misalign, ras_empty, ras_full, ras_err
  );
  modport slave (
    input  hold, mode, target,
    output PC, misalign, ras_empty, ras_full, ras_err
  );
`endif
endinterface

// File: rtl/pc_ras_unit.sv
// Fetch program counter with sequential/branch/jump/call/return modes and a circular RAS.
// Optional trap redirect and epc capture are enabled by defining PC_TRAP_EN.
module pc_ras_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input logic         Clock,
  input logic         Reset,
  pc_ras_unit_if.slave bus
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] M_SEQ      = 3'd0;
  localparam logic [2:0] M_BR_REL   = 3'd1;
  localparam logic [2:0] M_JMP_ABS  = 3'd2;
  localparam logic [2:0] M_CALL_REL = 3'd3;
  localparam logic [2:0] M_CALL_ABS = 3'd4;
  localparam logic [2:0] M_RET      = 3'd5;

  localparam logic [XLEN-1:0] INC_V   = XLEN'(INC);
  localparam logic [CW-1:0]   COUNT_MAX = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   count_q;
  logic            err_q;
  logic [PW-1:0]   ptr_dec;
  logic [XLEN-1:0] link;
  logic            ras_is_empty;
  logic            ras_is_full;
`ifdef PC_TRAP_EN
  logic [XLEN-1:0] epc_q;
`endif

  assign ptr_dec      = ptr_q - PW'(1);
  assign link         = pc_q + INC_V;
  assign ras_is_empty = (count_q == '0);
  assign ras_is_full  = (count_q == COUNT_MAX);

  // Slot ptr_q is the next free entry; a push when full lands on the oldest entry.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= RESET_VEC;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef PC_TRAP_EN
      epc_q   <= '0;
    end else if (bus.trap_req) begin
      pc_q  <= bus.trap_vec;
      epc_q <= pc_q;
`endif
    end else begin
      case (bus.mode)
        M_BR_REL:  pc_q <= pc_q + bus.target;
        M_JMP_ABS: pc_q <= bus.target;
        M_CALL_REL, M_CALL_ABS: begin
          pc_q           <= (bus.mode == M_CALL_REL) ? pc_q + bus.target : bus.target;
          ras_mem[ptr_q] <= link;
          ptr_q          <= ptr_q + PW'(1);
          if (ras_is_full) err_q   <= 1'b1;
          else             count_q <= count_q + CW'(1);
        end
        M_RET: begin
          if (ras_is_empty) begin
            pc_q  <= bus.target;
            err_q <= 1'b1;
          end else begin
            pc_q    <= ras_mem[ptr_dec];
            ptr_q   <= ptr_dec;
            count_q <= count_q - CW'(1);
          end
        end
        default: if (!bus.hold) pc_q <= link;
      endcase
    end
  end

  assign bus.PC        = pc_q;
  assign bus.misalign  = |pc_q[1:0];
  assign bus.ras_empty = ras_is_empty;
  assign bus.ras_full  = ras_is_full;
  assign bus.ras_err   = err_q;
`ifdef PC_TRAP_EN
  assign bus.epc       = epc_q;
`endif

endmodule
